weight_mem_writer: RTL
======================

// Module: weight_mem_writer
// PURPOSE
//   Write-side companion of the fold address generator. Accepts a stream of synopseFold
//   weight/threshold words on a valid/ready handshake and writes them to consecutive
//   memory addresses starting at baseAddress. Flags the region as loaded for the read side.
//   Sits between the host/DMA input stream and the per-PE weight BRAM write port.
// PARAMETERS
//   synopseFold    18  words per load = addresses written, base .. base+synopseFold-1 (>=1)
//   address_width  12  memory address width
//   data_width     32  width of one weight word
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   asynchronous, active-high reset
//   start        in   1   begin a load; sampled only in IDLE or DONE
//   baseAddress  in   AW  first write address; latched on accepted start
//   in_data      in   DW  incoming word
//   in_valid     in   1   in_data valid
//   in_ready     out  1   writer accepts a word this cycle
//   wr_en        out  1   memory write strobe, registered
//   wr_addr      out  AW  memory write address, registered
//   wr_data      out  DW  memory write data, registered
//   busy         out  1   high while in LOAD
//   load_done    out  1   one-cycle pulse with the final write
//   mem_valid    out  1   level: region fully written; cleared by next accepted start
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, cnt=0, base=0, wr_en=0, wr_addr=0, wr_data=0,
//     load_done=0, mem_valid=0. in_ready=0, busy=0.
//   - FSM IDLE -> LOAD on start. LOAD -> DONE on last accepted word. DONE -> LOAD on start.
//     No other transitions. start while in LOAD is ignored: no restart, base unchanged.
//   - Accepted start (IDLE/DONE): latch base<=baseAddress, cnt<=0, mem_valid<=0, go LOAD.
//     in_ready rises the following cycle.
//   - in_ready = (state==LOAD), decoded from registered state only; no in_valid path.
//   - Transfer = in_valid & in_ready. The next cycle has wr_en=1,
//     wr_addr=base+cnt (mod 2^AW), and wr_data=in_data. On that transfer cnt<=cnt+1.
//     A cycle without a transfer gives wr_en=0. wr_addr/wr_data hold their last values.
//   - Last transfer (cnt==synopseFold-1): cnt<=0, state<=DONE, in_ready low next cycle.
//     load_done=1 and mem_valid<=1 in the same cycle as the final wr_en.
//   - Throughput: 1 word/cycle. Latency: in transfer -> wr_en is 1 cycle.
//   - synopseFold==1: a single transfer completes the load.
//   - Address wrap: base+synopseFold-1 > 2^AW-1 wraps modulo 2^AW. No error flag.
//   - start on the same cycle as the last transfer: start is ignored (state is LOAD).
//   - in_valid in IDLE/DONE: ignored, no write.
//   - Reset mid-load: the load is discarded, mem_valid=0, a pending wr_en is dropped.
//   - cnt width CNT_W = $clog2(synopseFold+1). The add base+cnt is zero-extended to AW.
// STRUCTURE
//   - Shared package weight_mem_pkg:
//     - state enum {IDLE, LOAD, DONE}
//     - CNT_W function
//     - DEFAULT_FOLD = 18 and DEFAULT_AW = 12, shared with the address generator
//   - One sub-module, fold_counter: counts 0..synopseFold-1 on inc,
//     with a wrap pulse and sync clear. The read side also reuses it.
//   - Top holds the FSM, the base latch and the output registers.
// TESTING
//   - Reset then start with base=0x100. Stream 18 words, valid held high.
//     -> wr_en on 18 consecutive cycles, addr 0x100..0x111.
//     -> load_done and mem_valid on the 18th write. in_ready then low.
//   - Same load with in_valid toggled 1/0.
//     -> wr_en only one cycle after each transfer. Addresses stay gap-free. load_done once.
//   - base=0xFFA, fold=18 -> addresses 0xFFA..0xFFF, then 0x000..0x00B.
//     -> mem_valid set after the 0x00B write.
//   - start pulsed mid-load (after word 5).
//     -> ignored: addresses continue from base+5, one load_done.
//   - Assert rst after word 9.
//     -> all outputs 0 immediately (async). The next start reloads from word 0.
//   - start in DONE with base=0x200.
//     -> mem_valid drops next cycle. A second load writes 0x200..0x211.

Source files
------------

// File: rtl/weight_mem_pkg.sv
// Types and defaults shared by the weight memory writer and the fold address generator.
package weight_mem_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam int DEFAULT_FOLD = 18;
    localparam int DEFAULT_AW   = 12;

    // Counter width able to hold 0..fold.
    function automatic int cnt_width(input int fold);
        return $clog2(fold + 1);
    endfunction

endpackage

// File: rtl/weight_mem_writer_if.sv
// Word stream handshake feeding the weight memory writer.
interface weight_mem_writer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    modport master (output in_data, in_valid, input in_ready);
    modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/weight_mem_writer_fold_counter.sv
// Modulo-fold word counter: 0..FOLD-1 on inc, wrap pulses on the increment out of FOLD-1.
module fold_counter #(
    parameter int FOLD = 18,
    parameter int W    = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    localparam logic [W-1:0] CNT_MAX = W'(FOLD - 1);

    assign wrap = inc && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/weight_mem_writer.sv
// Streams synopseFold weight words into consecutive memory addresses from a latched base
// and flags the region valid for the read side once the last word is written.
module weight_mem_writer
    import weight_mem_pkg::*;
#(
    parameter int synopseFold   = DEFAULT_FOLD,
    parameter int address_width = DEFAULT_AW,
    parameter int data_width    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [address_width-1:0] baseAddress,
    weight_mem_writer_if.slave       stream,
    output logic                     wr_en,
    output logic [address_width-1:0] wr_addr,
    output logic [data_width-1:0]    wr_data,
    output logic                     busy,
    output logic                     load_done,
    output logic                     mem_valid
);
    localparam int CNT_W = cnt_width(synopseFold);

    state_t                   state, state_nxt;
    logic [address_width-1:0] base;
    logic [CNT_W-1:0]         cnt;
    logic                     cnt_wrap;
    logic                     ready;
    logic                     xfer;
    logic                     start_acc;

    // start only counts outside LOAD; a mid-load start must not disturb the running load.
    assign start_acc = start && (state != LOAD);
    assign xfer      = stream.in_valid && ready;

    fold_counter #(
        .FOLD (synopseFold),
        .W    (CNT_W)
    ) u_fold_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .inc  (xfer),
        .cnt  (cnt),
        .wrap (cnt_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = LOAD;
            LOAD:    if (cnt_wrap) state_nxt = DONE;
            DONE:    if (start)    state_nxt = LOAD;
            default:               state_nxt = IDLE;
        endcase
    end

    // Ready comes from registered state only, so there is no valid->ready path.
    always_comb begin
        ready           = (state == LOAD);
        busy            = (state == LOAD);
        stream.in_ready = ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            mem_valid <= 1'b0;
        end else begin
            wr_en     <= xfer;
            load_done <= cnt_wrap;
            if (start_acc)
                base <= baseAddress;
            if (xfer) begin
                wr_addr <= base + address_width'(cnt);
                wr_data <= stream.in_data;
            end
            if (start_acc)
                mem_valid <= 1'b0;
            else if (cnt_wrap)
                mem_valid <= 1'b1;
        end
    end

endmodule
